// File: rtl/acc_buf_rmw_pkg.sv
// Shared constants and the per-stage command record for the accumulate buffer.
package GLOBAL_PARAM;
    localparam int BATCH       = 4;
    localparam int ACC_W       = 32;
    localparam int ABUF_ADDR_W = 8;

    typedef struct packed {
        logic                   valid;
        logic [ABUF_ADDR_W-1:0] addr;
        logic [BATCH-1:0]       acc_en;
        logic                   acc_new;
    } acc_cmd_t;
endpackage

// File: rtl/acc_buf_rmw_if.sv
// Command and accumulate-SRAM bus bundle of the accumulate buffer RMW engine.
interface acc_buf_rmw_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int BATCH  = GLOBAL_PARAM::BATCH
);
    logic                    acc_valid;
    logic [ADDR_W-1:0]       abuf_addr;
    logic [BATCH-1:0]        abuf_acc_en;
    logic                    abuf_acc_new;
    logic [BATCH*DATA_W-1:0] mac_data;
    logic [ADDR_W-1:0]       buf_rd_addr;
    logic [BATCH*DATA_W-1:0] buf_rd_data;
    logic                    buf_wr_en;
    logic [ADDR_W-1:0]       buf_wr_addr;
    logic [BATCH*DATA_W-1:0] buf_wr_data;
    logic [BATCH-1:0]        buf_wr_mask;

    modport slave (
        input  acc_valid, abuf_addr, abuf_acc_en, abuf_acc_new,
        input  mac_data, buf_rd_data,
        output buf_rd_addr, buf_wr_en, buf_wr_addr,
        output buf_wr_data, buf_wr_mask
    );

    modport master (
        output acc_valid, abuf_addr, abuf_acc_en, abuf_acc_new,
        output mac_data, buf_rd_data,
        input  buf_rd_addr, buf_wr_en, buf_wr_addr,
        input  buf_wr_data, buf_wr_mask
    );
endinterface

// File: rtl/acc_buf_rmw_lane.sv
// One accumulator lane: hazard forward-select, then add (or saturating add
// when ABUF_SAT_EN is defined).
module acc_lane_add #(
    parameter int DATA_W = 32
) (
    input  logic              s2_hit_i,
    input  logic [DATA_W-1:0] s2_data_i,
    input  logic              s3_hit_i,
    input  logic [DATA_W-1:0] s3_data_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic [DATA_W-1:0] mac_i,
    input  logic              new_i,
`ifdef ABUF_SAT_EN
    input  logic              en_i,
    output logic              sat_o,
`endif
    output logic [DATA_W-1:0] sum_o
);
    logic [DATA_W-1:0] old;

    // Youngest in-flight write wins over the older one and the SRAM.
    always_comb begin
        old = rd_data_i;
        if (s3_hit_i) old = s3_data_i;
        if (s2_hit_i) old = s2_data_i;
    end

`ifdef ABUF_SAT_EN
    localparam logic [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W:0] wide;
    logic            ovf;

    always_comb begin
        wide  = {old[DATA_W-1], old} + {mac_i[DATA_W-1], mac_i};
        ovf   = wide[DATA_W] ^ wide[DATA_W-1];
        sum_o = mac_i;
        sat_o = 1'b0;
        if (!new_i) begin
            sum_o = ovf ? (wide[DATA_W] ? MINV : MAXV) : wide[DATA_W-1:0];
            sat_o = en_i & ovf;
        end
    end
`else
    assign sum_o = new_i ? mac_i : old + mac_i;
`endif
endmodule

// File: rtl/acc_buf_rmw.sv
// Pipelined read-modify-write engine for the conv accumulate buffer.
// Define ABUF_SAT_EN for signed saturating accumulation plus sat_flag.
module acc_buf_rmw #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int BATCH  = GLOBAL_PARAM::BATCH
) (
    input  logic         clk,
    input  logic         rst,
    acc_buf_rmw_if.slave bus,
    output logic         busy,
`ifdef ABUF_SAT_EN
    output logic         sat_flag,
`endif
    output logic [15:0]  wr_cnt
);
    import GLOBAL_PARAM::*;

    acc_cmd_t                s1_q, s1_d;
    logic [BATCH*DATA_W-1:0] s1_mac_q;
    logic [BATCH*DATA_W-1:0] sum;

    logic                    s2_vld_q, s3_vld_q;
    logic [ADDR_W-1:0]       s2_addr_q, s3_addr_q;
    logic [BATCH-1:0]        s2_mask_q, s3_mask_q;
    logic [BATCH*DATA_W-1:0] s2_data_q, s3_data_q;
    logic [15:0]             wr_cnt_q;
    logic                    s2_hit, s3_hit;

    assign bus.buf_rd_addr = bus.abuf_addr;

    // Bubbles carry an empty mask so they never act as a forward source.
    always_comb begin
        s1_d         = '0;
        s1_d.valid   = bus.acc_valid;
        s1_d.addr    = bus.abuf_addr;
        s1_d.acc_en  = bus.acc_valid ? bus.abuf_acc_en : '0;
        s1_d.acc_new = bus.abuf_acc_new;
    end

    assign s2_hit = s2_vld_q && (s2_addr_q == s1_q.addr);
    assign s3_hit = s3_vld_q && (s3_addr_q == s1_q.addr);

`ifdef ABUF_SAT_EN
    logic [BATCH-1:0] lane_sat;
    logic             sat_q;
`endif

    for (genvar i = 0; i < BATCH; i++) begin : g_lane
        acc_lane_add #(.DATA_W(DATA_W)) u_lane (
            .s2_hit_i  (s2_hit & s2_mask_q[i]),
            .s2_data_i (s2_data_q[i*DATA_W +: DATA_W]),
            .s3_hit_i  (s3_hit & s3_mask_q[i]),
            .s3_data_i (s3_data_q[i*DATA_W +: DATA_W]),
            .rd_data_i (bus.buf_rd_data[i*DATA_W +: DATA_W]),
            .mac_i     (s1_mac_q[i*DATA_W +: DATA_W]),
            .new_i     (s1_q.acc_new),
`ifdef ABUF_SAT_EN
            .en_i      (s1_q.acc_en[i]),
            .sat_o     (lane_sat[i]),
`endif
            .sum_o     (sum[i*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_vld_q  <= 1'b0;
            s2_mask_q <= '0;
            s3_vld_q  <= 1'b0;
            s3_mask_q <= '0;
            wr_cnt_q  <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_vld_q  <= s1_q.valid;
            s2_mask_q <= s1_q.acc_en;
            s3_vld_q  <= s2_vld_q;
            s3_mask_q <= s2_mask_q;
            if (s2_vld_q) wr_cnt_q <= wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        s1_mac_q  <= bus.mac_data;
        s2_addr_q <= s1_q.addr;
        s2_data_q <= sum;
        s3_addr_q <= s2_addr_q;
        s3_data_q <= s2_data_q;
    end

`ifdef ABUF_SAT_EN
    always_ff @(posedge clk) begin
        if (rst) sat_q <= 1'b0;
        else if (s1_q.valid && |lane_sat) sat_q <= 1'b1;
    end

    assign sat_flag = sat_q;
`endif

    assign bus.buf_wr_en   = s2_vld_q;
    assign bus.buf_wr_addr = s2_addr_q;
    assign bus.buf_wr_data = s2_data_q;
    assign bus.buf_wr_mask = s2_mask_q;
    assign busy            = s1_q.valid | s2_vld_q;
    assign wr_cnt          = wr_cnt_q;
endmodule

// File: tb/tb_acc_buf_rmw.sv
// Randomized and directed bench for acc_buf_rmw against an in-order memory model.
module tb_acc_buf_rmw;
    import GLOBAL_PARAM::*;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NB = BATCH;
    localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (DW - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    acc_buf_rmw_if #(.ADDR_W(AW), .DATA_W(DW), .BATCH(NB)) bus ();
    logic        busy;
    logic [15:0] wr_cnt;
`ifdef ABUF_SAT_EN
    logic        sat_flag;
`endif

    acc_buf_rmw #(.ADDR_W(AW), .DATA_W(DW), .BATCH(NB)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
`ifdef ABUF_SAT_EN
        .sat_flag (sat_flag),
`endif
        .wr_cnt   (wr_cnt)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // SRAM: 1-cycle read, masked write, old data on same-cycle collision.
    logic [NB*DW-1:0] mem [256] = '{default: '0};
    always @(posedge clk) begin
        bus.buf_rd_data <= mem[bus.buf_rd_addr];
        if (bus.buf_wr_en)
            for (int l = 0; l < NB; l++)
                if (bus.buf_wr_mask[l])
                    mem[bus.buf_wr_addr][l*DW +: DW] <= bus.buf_wr_data[l*DW +: DW];
    end

    // Reference: commands retire in order against a committed image.
    typedef struct {
        int               due;
        logic [AW-1:0]    a;
        logic [NB-1:0]    en;
        logic             nw;
        logic [NB*DW-1:0] mac;
    } cmd_s;

    typedef struct {
        logic [AW-1:0]    a;
        logic [NB*DW-1:0] d;
        logic [NB-1:0]    m;
    } wr_s;

    logic [DW-1:0] gold [256][NB] = '{default: '0};
    cmd_s pq[$];
    wr_s  wlog[$];
    int   cyc = 0;
    int   m_cnt = 0;
    bit   m_sat = 0;
    bit   chk_en = 0;

    function automatic logic [DW-1:0] acc_ref(input logic [DW-1:0] o,
                                              input logic [DW-1:0] m,
                                              output bit s);
        longint r;
        r = longint'($signed(o)) + longint'($signed(m));
        s = 0;
`ifdef ABUF_SAT_EN
        if (r > MAXV) begin s = 1; r = MAXV; end
        if (r < MINV) begin s = 1; r = MINV; end
`endif
        return DW'(r);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            pq.delete();
            m_cnt = 0;
            m_sat = 0;
        end else if (bus.acc_valid) begin
            pq.push_back('{due: cyc + 1, a: bus.abuf_addr, en: bus.abuf_acc_en,
                           nw: bus.abuf_acc_new, mac: bus.mac_data});
        end
    end

    cmd_s          cc;
    logic [DW-1:0] ev;
    bit            sflag;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, pq.size() != 0);
            chk("wr_cnt", wr_cnt, 16'(m_cnt));
            if (bus.buf_wr_en === 1'b1)
                wlog.push_back('{a: bus.buf_wr_addr, d: bus.buf_wr_data,
                                 m: bus.buf_wr_mask});
            if (pq.size() != 0 && pq[0].due == cyc) begin
                cc = pq.pop_front();
                chk("wr_en", bus.buf_wr_en, 1);
                chk("wr_addr", bus.buf_wr_addr, cc.a);
                chk("wr_mask", bus.buf_wr_mask, cc.en);
                for (int l = 0; l < NB; l++) begin
                    if (cc.en[l]) begin
                        ev = cc.mac[l*DW +: DW];
                        if (!cc.nw) begin
                            ev = acc_ref(gold[cc.a][l], ev, sflag);
                            if (sflag) m_sat = 1;
                        end
                        chk($sformatf("wr_data[%0d]", l),
                            bus.buf_wr_data[l*DW +: DW], ev);
                        gold[cc.a][l] = ev;
                    end
                end
                m_cnt++;
            end else begin
                chk("wr_en_idle", bus.buf_wr_en, 0);
            end
`ifdef ABUF_SAT_EN
            chk("sat_flag", sat_flag, m_sat);
`endif
        end
    end

    function automatic logic [NB*DW-1:0] splat(input logic [DW-1:0] v);
        return {NB{v}};
    endfunction

    task automatic drive(input bit v, input logic [AW-1:0] a,
                         input logic [NB-1:0] en, input bit nw,
                         input logic [NB*DW-1:0] m);
        bus.acc_valid    = v;
        bus.abuf_addr    = a;
        bus.abuf_acc_en  = en;
        bus.abuf_acc_new = nw;
        bus.mac_data     = m;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            drive(0, AW'($urandom), '1, 0, '0);
    endtask

    function automatic wr_s wget(input int i);
        wr_s w;
        w = '{a: '0, d: '0, m: '0};
        if (wlog.size() > i) return wlog[i];
        n_chk++;
        n_err++;
        $display("FAIL wlog[%0d]: got %0d writes required more", i, wlog.size());
        return w;
    endfunction

    localparam logic [NB-1:0] ALL = '1;
    localparam logic [NB-1:0] EV  = NB'(4'b0101);

    wr_s           w;
    logic [DW-1:0] lv;

    initial begin
        drive(0, 0, 0, 0, '0);
        drive(0, 0, 0, 0, '0);
        rst    = 0;
        chk_en = 1;
        chk("rst_busy", busy, 0);
        chk("rst_wr_cnt", wr_cnt, 0);
        chk("rst_wr_en", bus.buf_wr_en, 0);

        wlog.delete();
        drive(1, 5, ALL, 1, splat(3));
        idle(3);
        w = wget(0);
        chk("t1_addr", w.a, 5);
        chk("t1_mask", w.m, ALL);
        chk("t1_lane0", w.d[0 +: DW], 3);
        chk("t1_lane3", w.d[3*DW +: DW], 3);
        chk("t1_cnt", wr_cnt, 1);

        wlog.delete();
        drive(1, 5, ALL, 1, splat(3));
        drive(1, 5, ALL, 0, splat(4));
        idle(3);
        w = wget(1);
        chk("t2_lane0", w.d[0 +: DW], 7);
        chk("t2_lane2", w.d[2*DW +: DW], 7);

        wlog.delete();
        drive(1, 5, ALL, 1, splat(3));
        drive(1, 9, ALL, 1, splat(0));
        drive(1, 5, ALL, 0, splat(10));
        idle(3);
        w = wget(2);
        chk("t3_addr", w.a, 5);
        chk("t3_lane1", w.d[DW +: DW], 13);

        drive(1, 2, ALL, 1, splat(100));
        idle(3);
        wlog.delete();
        drive(1, 2, EV, 0, splat(1));
        drive(1, 2, ALL, 0, splat(1));
        idle(3);
        w = wget(0);
        chk("t4a_mask", w.m, EV);
        chk("t4a_lane0", w.d[0 +: DW], 101);
        chk("t4a_lane2", w.d[2*DW +: DW], 101);
        w = wget(1);
        chk("t4b_lane0", w.d[0 +: DW], 102);
        chk("t4b_lane1", w.d[DW +: DW], 101);
        chk("t4b_lane2", w.d[2*DW +: DW], 102);
        chk("t4b_lane3", w.d[3*DW +: DW], 101);

        for (int k = 0; k < 600; k++) begin
            logic [NB*DW-1:0] m;
            for (int l = 0; l < NB; l++)
                m[l*DW +: DW] = ($urandom % 3 == 0) ? DW'($urandom)
                                                     : DW'($urandom_range(0, 255)) - DW'(128);
            drive($urandom % 4 != 0, AW'($urandom % 4), NB'($urandom),
                  $urandom % 5 == 0, m);
        end
        idle(3);
        for (int a = 0; a < 4; a++)
            for (int l = 0; l < NB; l++)
                chk($sformatf("mem[%0d][%0d]", a, l), mem[a][l*DW +: DW], gold[a][l]);

        drive(1, 20, ALL, 1, splat(1));
        drive(1, 21, ALL, 1, splat(2));
        chk("mid_busy", busy, 1);
        rst = 1;
        drive(1, 22, ALL, 1, splat(3));
        rst = 0;
        wlog.delete();
        idle(4);
        chk("rst_nwr", wlog.size(), 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_cnt", wr_cnt, 0);
        chk("rst2_mem21", mem[21][0 +: DW], 0);

        drive(1, 7, ALL, 1, splat(32'h7FFF_FFF0));
        idle(3);
`ifdef ABUF_SAT_EN
        chk("sat_pre", sat_flag, 0);
`endif
        wlog.delete();
        drive(1, 7, ALL, 0, splat(32'h20));
        idle(3);
        w = wget(0);
`ifdef ABUF_SAT_EN
        lv = 32'h7FFF_FFFF;
        chk("sat_flag_set", sat_flag, 1);
`else
        lv = 32'h8000_0010;
`endif
        chk("ovf_lane0", w.d[0 +: DW], lv);
        chk("ovf_lane3", w.d[3*DW +: DW], lv);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
